// File: rtl/mul_mac_seq.sv
// Sequencer issuing N multiply-accumulate ops over consecutive register-file address pairs.
// Build option: define MUL_SEQ_SAT_EN to append a saturate-MR op between drain and done.
module mul_mac_seq #(
    parameter int unsigned RF_ADDRSIZE = 4,
    parameter int unsigned CNT_WIDTH   = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   seq_start,
    input  logic [CNT_WIDTH-1:0]   seq_cnt,
    input  logic [RF_ADDRSIZE-1:0] seq_rx_base,
    input  logic [RF_ADDRSIZE-1:0] seq_ry_base,
    input  logic [3:0]             seq_dtsts,
    input  logic                   seq_sub,
    input  logic                   seq_clr,
    input  logic                   seq_stall,
    input  logic                   mul_ps_mv,
    output logic [RF_ADDRSIZE-1:0] rf_rx_addr,
    output logic [RF_ADDRSIZE-1:0] rf_ry_addr,
    output logic                   ps_mul_en,
    output logic                   ps_mul_otreg,
    output logic [3:0]             ps_mul_dtsts,
    output logic [1:0]             ps_mul_cls,
    output logic [1:0]             ps_mul_sc,
    output logic                   seq_busy,
    output logic                   seq_done,
    output logic                   seq_mv
);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StDrain,
`ifdef MUL_SEQ_SAT_EN
        StSat,
`endif
        StDone
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CntOne = 1;

    state_e                 state_q;
    logic [CNT_WIDTH-1:0]   idx_q;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [RF_ADDRSIZE-1:0] rx_base_q;
    logic [RF_ADDRSIZE-1:0] ry_base_q;
    logic [3:0]             dtsts_q;
    logic                   sub_q;
    logic                   clr_q;
    logic                   mac_issued_q;
    logic                   seq_mv_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            cnt_q        <= '0;
            rx_base_q    <= '0;
            ry_base_q    <= '0;
            dtsts_q      <= '0;
            sub_q        <= 1'b0;
            clr_q        <= 1'b0;
            mac_issued_q <= 1'b0;
            seq_mv_q     <= 1'b0;
        end else begin
            // Overflow flag arrives one cycle after the accumulating op that caused it.
            mac_issued_q <= ps_mul_en && (ps_mul_cls != 2'b00);
            if (mac_issued_q && mul_ps_mv) begin
                seq_mv_q <= 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (seq_start) begin
                        cnt_q     <= seq_cnt;
                        rx_base_q <= seq_rx_base;
                        ry_base_q <= seq_ry_base;
                        dtsts_q   <= seq_dtsts;
                        sub_q     <= seq_sub;
                        clr_q     <= seq_clr;
                        idx_q     <= '0;
                        seq_mv_q  <= 1'b0;
                        state_q   <= (seq_cnt != '0) ? StIssue : StDone;
                    end
                end
                StIssue: begin
                    if (!seq_stall) begin
                        idx_q <= idx_q + CntOne;
                        if (idx_q == cnt_q - CntOne) begin
                            state_q <= StDrain;
                        end
                    end
                end
`ifdef MUL_SEQ_SAT_EN
                StDrain: state_q <= StSat;
                StSat:   state_q <= StDone;
`else
                StDrain: state_q <= StDone;
`endif
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        rf_rx_addr   = '0;
        rf_ry_addr   = '0;
        ps_mul_en    = 1'b0;
        ps_mul_otreg = 1'b0;
        ps_mul_dtsts = '0;
        ps_mul_cls   = 2'b00;
        ps_mul_sc    = 2'b00;
        case (state_q)
            StIssue: begin
                // Address arithmetic wraps at the register-file size.
                rf_rx_addr   = rx_base_q + RF_ADDRSIZE'(idx_q);
                rf_ry_addr   = ry_base_q + RF_ADDRSIZE'(idx_q);
                ps_mul_en    = !seq_stall;
                ps_mul_otreg = 1'b1;
                ps_mul_dtsts = dtsts_q;
                ps_mul_cls   = (idx_q == '0 && clr_q) ? 2'b01 : {1'b1, sub_q};
            end
`ifdef MUL_SEQ_SAT_EN
            StSat: begin
                ps_mul_en    = 1'b1;
                ps_mul_otreg = 1'b1;
                ps_mul_dtsts = dtsts_q;
                ps_mul_sc    = 2'b11;
            end
`endif
            default: ;
        endcase
    end

    assign seq_busy = (state_q != StIdle);
    assign seq_done = (state_q == StDone);
    assign seq_mv   = seq_mv_q;

endmodule

// File: tb/tb_mul_mac_seq.sv
// Self-checking bench for mul_mac_seq: scoreboard of expected MAC issues per run.
// Works with or without MUL_SEQ_SAT_EN defined.
module tb_mul_mac_seq;

    localparam int unsigned AW = 4;
    localparam int unsigned CW = 5;
`ifdef MUL_SEQ_SAT_EN
    localparam int SatCyc = 1;
`else
    localparam int SatCyc = 0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          seq_start;
    logic [CW-1:0] seq_cnt;
    logic [AW-1:0] seq_rx_base;
    logic [AW-1:0] seq_ry_base;
    logic [3:0]    seq_dtsts;
    logic          seq_sub;
    logic          seq_clr;
    logic          seq_stall;
    logic          mul_ps_mv;
    logic [AW-1:0] rf_rx_addr;
    logic [AW-1:0] rf_ry_addr;
    logic          ps_mul_en;
    logic          ps_mul_otreg;
    logic [3:0]    ps_mul_dtsts;
    logic [1:0]    ps_mul_cls;
    logic [1:0]    ps_mul_sc;
    logic          seq_busy;
    logic          seq_done;
    logic          seq_mv;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] rx;
        logic [3:0] ry;
        logic [1:0] cls;
        logic [3:0] dtsts;
    } op_t;

    typedef struct {
        int         cnt;
        int         rxb;
        int         ryb;
        bit         clr;
        bit         sub;
        logic [3:0] dtsts;
        int         stall_at;
        int         mv_at;
    } scn_t;

    op_t exp_q[$];

    mul_mac_seq #(
        .RF_ADDRSIZE(AW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .seq_start   (seq_start),
        .seq_cnt     (seq_cnt),
        .seq_rx_base (seq_rx_base),
        .seq_ry_base (seq_ry_base),
        .seq_dtsts   (seq_dtsts),
        .seq_sub     (seq_sub),
        .seq_clr     (seq_clr),
        .seq_stall   (seq_stall),
        .mul_ps_mv   (mul_ps_mv),
        .rf_rx_addr  (rf_rx_addr),
        .rf_ry_addr  (rf_ry_addr),
        .ps_mul_en   (ps_mul_en),
        .ps_mul_otreg(ps_mul_otreg),
        .ps_mul_dtsts(ps_mul_dtsts),
        .ps_mul_cls  (ps_mul_cls),
        .ps_mul_sc   (ps_mul_sc),
        .seq_busy    (seq_busy),
        .seq_done    (seq_done),
        .seq_mv      (seq_mv)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        logic [24:0] outs;
        reset = 1'b1; seq_start = 1'b0; seq_cnt = '0; seq_rx_base = '0; seq_ry_base = '0;
        seq_dtsts = '0; seq_sub = 1'b0; seq_clr = 1'b0; seq_stall = 1'b0; mul_ps_mv = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        outs = {rf_rx_addr, rf_ry_addr, ps_mul_en, ps_mul_otreg, ps_mul_dtsts, ps_mul_cls,
                ps_mul_sc, seq_busy, seq_done, seq_mv, 4'b0};
        n_checks++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", outs);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (ps_mul_en !== 1'b0 || seq_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: en=%b busy=%b want 0 0", ps_mul_en, seq_busy);
        end
    endtask

    task automatic test_runs();
        scn_t scn[4];
        op_t  op;
        int   a, cyc, ops, sat_ops, done_cyc, exp_done;
        scn[0] = '{cnt: 3, rxb: 2,  ryb: 5,  clr: 1'b1, sub: 1'b0, dtsts: 4'h5, stall_at: 0, mv_at: 0};
        scn[1] = '{cnt: 4, rxb: 0,  ryb: 8,  clr: 1'b1, sub: 1'b1, dtsts: 4'hA, stall_at: 2, mv_at: 0};
        scn[2] = '{cnt: 4, rxb: 6,  ryb: 1,  clr: 1'b0, sub: 1'b1, dtsts: 4'h3, stall_at: 0, mv_at: 3};
        scn[3] = '{cnt: 3, rxb: 15, ryb: 14, clr: 1'b0, sub: 1'b0, dtsts: 4'hC, stall_at: 0, mv_at: 0};
        for (int k = 0; k < 4; k++) begin
            exp_q.delete();
            for (int i = 0; i < scn[k].cnt; i++) begin
                a = scn[k].rxb + i; op.rx = a[3:0];
                a = scn[k].ryb + i; op.ry = a[3:0];
                op.cls   = (i == 0 && scn[k].clr) ? 2'b01 : {1'b1, scn[k].sub};
                op.dtsts = scn[k].dtsts;
                exp_q.push_back(op);
            end
            exp_done = scn[k].cnt + 2 + SatCyc + ((scn[k].stall_at != 0) ? 1 : 0);
            @(negedge clk);
            seq_start = 1'b1; seq_cnt = CW'(scn[k].cnt);
            seq_rx_base = AW'(scn[k].rxb); seq_ry_base = AW'(scn[k].ryb);
            seq_clr = scn[k].clr; seq_sub = scn[k].sub; seq_dtsts = scn[k].dtsts;
            seq_stall = 1'b0; mul_ps_mv = 1'b0;
            ops = 0; sat_ops = 0; done_cyc = 0;
            for (cyc = 1; cyc <= 40 && done_cyc == 0; cyc++) begin
                @(negedge clk);
                // A second start while busy, with different operands, must be ignored.
                seq_start = (cyc == 2);
                if (cyc == 2) begin
                    seq_cnt = 5'd1; seq_rx_base = 4'h9; seq_clr = ~seq_clr; seq_dtsts = 4'hF;
                end
                seq_stall = (cyc == scn[k].stall_at);
                mul_ps_mv = (cyc == scn[k].mv_at);
                #1;
                n_checks++;
                if (seq_busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL busy run%0d cyc%0d: got %b want 1", k, cyc, seq_busy);
                end
                if (cyc == 1) begin
                    n_checks++;
                    if (seq_mv !== 1'b0) begin
                        n_fail++;
                        $display("FAIL mv_cleared run%0d: got %b want 0", k, seq_mv);
                    end
                end
                if (seq_stall) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL stall_hold run%0d: no op pending", k);
                    end else if (ps_mul_en !== 1'b0 || rf_rx_addr !== exp_q[0].rx ||
                                 rf_ry_addr !== exp_q[0].ry) begin
                        n_fail++;
                        $display("FAIL stall_hold run%0d: en=%b rx=%0d ry=%0d want en=0 rx=%0d ry=%0d",
                                 k, ps_mul_en, rf_rx_addr, rf_ry_addr, exp_q[0].rx, exp_q[0].ry);
                    end
                end else if (ps_mul_en === 1'b1) begin
                    n_checks++;
                    if (exp_q.size() > 0) begin
                        op = exp_q.pop_front();
                        ops++;
                        if (rf_rx_addr !== op.rx || rf_ry_addr !== op.ry || ps_mul_cls !== op.cls ||
                            ps_mul_dtsts !== op.dtsts || ps_mul_otreg !== 1'b1 ||
                            ps_mul_sc !== 2'b00) begin
                            n_fail++;
                            $display("FAIL mac_op run%0d op%0d: rx=%0d ry=%0d cls=%b dt=%h ot=%b sc=%b want rx=%0d ry=%0d cls=%b dt=%h ot=1 sc=00",
                                     k, ops, rf_rx_addr, rf_ry_addr, ps_mul_cls, ps_mul_dtsts,
                                     ps_mul_otreg, ps_mul_sc, op.rx, op.ry, op.cls, op.dtsts);
                        end
                    end else begin
                        sat_ops++;
                        if (SatCyc == 0 || ps_mul_cls !== 2'b00 || ps_mul_sc !== 2'b11 ||
                            ps_mul_otreg !== 1'b1 || ps_mul_dtsts !== scn[k].dtsts) begin
                            n_fail++;
                            $display("FAIL extra_en run%0d cyc%0d: cls=%b sc=%b ot=%b dt=%h want sat op (enabled=%0d)",
                                     k, cyc, ps_mul_cls, ps_mul_sc, ps_mul_otreg, ps_mul_dtsts, SatCyc);
                        end
                    end
                end
                if (seq_done === 1'b1) done_cyc = cyc;
            end
            seq_start = 1'b0; seq_stall = 1'b0; mul_ps_mv = 1'b0;
            n_checks++;
            if (done_cyc != exp_done || ops != scn[k].cnt || sat_ops != SatCyc) begin
                n_fail++;
                $display("FAIL run_length run%0d: done@%0d ops=%0d sat=%0d want done@%0d ops=%0d sat=%0d",
                         k, done_cyc, ops, sat_ops, exp_done, scn[k].cnt, SatCyc);
            end
            n_checks++;
            if (seq_mv !== (scn[k].mv_at != 0)) begin
                n_fail++;
                $display("FAIL mv_at_done run%0d: got %b want %b", k, seq_mv, scn[k].mv_at != 0);
            end
            @(negedge clk);
            #1;
            n_checks++;
            if (seq_done !== 1'b0 || seq_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL done_pulse run%0d: done=%b busy=%b want 0 0", k, seq_done, seq_busy);
            end
        end
    endtask

    task automatic test_zero_cnt();
        @(negedge clk);
        seq_start = 1'b1; seq_cnt = '0; mul_ps_mv = 1'b1;
        #1;
        n_checks++;
        if (ps_mul_en !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_en_c0: got %b want 0", ps_mul_en);
        end
        @(negedge clk);
        seq_start = 1'b0;
        #1;
        n_checks++;
        if (seq_done !== 1'b1 || ps_mul_en !== 1'b0 || seq_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_done: done=%b en=%b busy=%b want 1 0 1", seq_done, ps_mul_en, seq_busy);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (seq_done !== 1'b0 || seq_busy !== 1'b0 || seq_mv !== 1'b0 || ps_mul_en !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_after: done=%b busy=%b mv=%b en=%b want 0 0 0 0",
                     seq_done, seq_busy, seq_mv, ps_mul_en);
        end
        mul_ps_mv = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [24:0] outs;
        @(negedge clk);
        seq_start = 1'b1; seq_cnt = 5'd10; seq_rx_base = 4'd3; seq_ry_base = 4'd7;
        seq_dtsts = 4'hA; seq_clr = 1'b0; seq_sub = 1'b0;
        @(negedge clk);
        seq_start = 1'b0;
        @(negedge clk);
        mul_ps_mv = 1'b1;
        #1;
        n_checks++;
        if (ps_mul_en !== 1'b1 || rf_rx_addr !== 4'd4) begin
            n_fail++;
            $display("FAIL mid_issue: en=%b rx=%0d want 1 4", ps_mul_en, rf_rx_addr);
        end
        @(negedge clk);
        reset = 1'b1;
        mul_ps_mv = 1'b0;
        @(negedge clk);
        #1;
        outs = {rf_rx_addr, rf_ry_addr, ps_mul_en, ps_mul_otreg, ps_mul_dtsts, ps_mul_cls,
                ps_mul_sc, seq_busy, seq_done, seq_mv, 4'b0};
        n_checks++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got %h want 0", outs);
        end
        reset = 1'b0;
        @(negedge clk);
        seq_start = 1'b1; seq_cnt = 5'd1; seq_rx_base = 4'd4; seq_ry_base = 4'd9;
        seq_clr = 1'b1;
        @(negedge clk);
        seq_start = 1'b0;
        #1;
        n_checks++;
        if (ps_mul_en !== 1'b1 || rf_rx_addr !== 4'd4 || rf_ry_addr !== 4'd9 ||
            ps_mul_cls !== 2'b01) begin
            n_fail++;
            $display("FAIL restart_after_reset: en=%b rx=%0d ry=%0d cls=%b want 1 4 9 01",
                     ps_mul_en, rf_rx_addr, rf_ry_addr, ps_mul_cls);
        end
        repeat (6) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_runs();
        test_zero_cnt();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_mac_seq.md
MUL_MAC_SEQ -- requirements
Module: mul_mac_seq

Interface
REQ-001 SHALL have parameter RF_ADDRSIZE, default 4, register-file address width.
REQ-002 SHALL have parameter CNT_WIDTH, default 5, MAC count width.
REQ-003 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port seq_start  in  1  start request, sampled in IDLE only.
REQ-006 SHALL have port seq_cnt  in  CNT_WIDTH  number of MAC operations N, sampled at start.
REQ-007 SHALL have ports seq_rx_base, seq_ry_base  in  RF_ADDRSIZE  first Rx/Ry addresses, sampled at start.
REQ-008 SHALL have port seq_dtsts  in  4  multiplier data status {ryUbS,rxUbS,IbF,rnd}, sampled at start.
REQ-009 SHALL have ports seq_sub, seq_clr  in  1  accumulate-subtract select; first op is plain product (clears MR).
REQ-010 SHALL have port seq_stall  in  1  hold issue for the current cycle.
REQ-011 SHALL have port mul_ps_mv  in  1  multiplier overflow flag.
REQ-012 SHALL have ports rf_rx_addr, rf_ry_addr  out  RF_ADDRSIZE  register-file read addresses.
REQ-013 SHALL have ports ps_mul_en, ps_mul_otreg  out  1; ps_mul_dtsts  out  4; ps_mul_cls, ps_mul_sc  out  2  multiplier control.
REQ-014 SHALL have ports seq_busy, seq_done, seq_mv  out  1  busy level; one-cycle done pulse; sticky overflow.

Function
REQ-015 SHALL implement states IDLE, ISSUE, DRAIN, SAT, DONE.
REQ-016 IDLE: seq_start=1 and seq_cnt!=0 SHALL latch the inputs, clear index and seq_mv, and go to ISSUE next cycle.
REQ-017 IDLE: seq_start=1 and seq_cnt==0 SHALL go to DONE without asserting ps_mul_en.
REQ-018 ISSUE, seq_stall=0: ps_mul_en=1, ps_mul_otreg=1, ps_mul_sc=00, ps_mul_dtsts=latched status, and the address index SHALL increment.
REQ-019 ISSUE: ps_mul_cls SHALL be 01 when index==0 and clr latched, else {1,sub}, i.e. 10 or 11.
REQ-020 ISSUE: rf_rx_addr = rx_base+index and rf_ry_addr = ry_base+index, both modulo 2^RF_ADDRSIZE, with wrap permitted.
REQ-021 ISSUE, seq_stall=1: ps_mul_en=0 and index held; the addresses SHALL stay on the held index.
REQ-022 The op issued with index==N-1 (not stalled) SHALL move to DRAIN.
REQ-023 DRAIN, one cycle: ps_mul_en=0; go to SAT if MUL_SEQ_SAT_EN is defined, else DONE.
REQ-024 SAT: ps_mul_en=1, otreg=1, cls=00, sc=11, dtsts=latched status, one cycle, ignores seq_stall; then go to DONE.
REQ-025 DONE: seq_done=1 for one cycle; return to IDLE.
REQ-026 seq_busy SHALL be 1 in every state except IDLE.
REQ-027 seq_mv SHALL be set when mul_ps_mv=1 in the cycle after any cycle with ps_mul_en=1 and cls!=00; it holds until the next accepted start.
REQ-028 seq_start while busy SHALL be ignored and have no side effect.
REQ-029 In states other than ISSUE and SAT: ps_mul_en=0, and the remaining ps_mul_* and rf_* outputs are 0.
REQ-030 A full run without stalls SHALL take N+2 cycles from start to done (N+3 with SAT).

Reset
REQ-031 While reset=1 at a rising edge: state=IDLE, index=0, latched inputs=0, and all outputs 0 next cycle, including mid-run.
REQ-032 ps_mul_en SHALL be 0 in the first cycle after reset, so the multiplier sees no spurious enable.

Configuration
REQ-033 Macro MUL_SEQ_SAT_EN defined: DRAIN goes to SAT, issuing a SAT MR before done.
REQ-034 Macro MUL_SEQ_SAT_EN undefined: the SAT state and its logic are absent, and DRAIN goes directly to DONE.

Verification
REQ-035 start, cnt=3, bases 2/5, clr=1, sub=0, no stall -> addresses (2,5),(3,6),(4,7), cls 01,10,10, done at cycle 5 (6 with SAT).
REQ-036 cnt=4, seq_stall high in the 2nd issue cycle -> en low that cycle, address held, 4 ops total, done one cycle later than unstalled.
REQ-037 rx_base=15, cnt=3, RF_ADDRSIZE=4 -> rf_rx_addr 15,0,1.
REQ-038 cnt=0 -> seq_done one cycle after start, ps_mul_en never 1.
REQ-039 mul_ps_mv=1 after the 2nd op -> seq_mv=1 through done; the next start clears it.
REQ-040 reset asserted mid-ISSUE -> next cycle IDLE, all outputs 0; start during busy ignored.
